// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
//   Shares the single port of a 16-word data memory between the main pipeline
//   (m_*) and a companion unit (c_*). Each access takes an IDLE (arbitrate)
//   cycle followed by exactly one ACCESS cycle. The result (rvalid/err) is
//   reported in the following IDLE cycle, which also arbitrates the next access.
//   Main has priority. The companion wins once it has lost MAX_WAIT arbitrations
//   in a row. MAX_WAIT = 0 gives the companion fixed priority.
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   m_req/m_we/m_addr/m_wdata  main request (held until m_gnt)
//   m_gnt/m_rvalid/m_rdata/m_err  main grant, read-return and error pulses
//   c_*                        same set for the companion unit
//   dm_rd/dm_wr/dm_addr/dm_wdata  memory port (memory writes on negedge clk)
//   dm_rdata                   combinational read data from the memory
module dm_access_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_gnt,
  output logic              m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_err,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Word-aligned and inside the 16-word (64-byte) memory.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a < ADDR_W'(64));
  endfunction

  state_t            state;
  logic [CW-1:0]     wait_cnt;
  logic              win_c;
  logic              we_q;
  logic              ok_q;
  logic [DATA_W-1:0] rdata_p1;

  logic              pick_c;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;

  always_comb begin
    pick_c    = c_req & (~m_req | (wait_cnt == WAIT_LIM));
    sel_we    = pick_c ? c_we    : m_we;
    sel_addr  = pick_c ? c_addr  : m_addr;
    sel_wdata = pick_c ? c_wdata : m_wdata;
    sel_ok    = addr_ok(sel_addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      win_c    <= 1'b0;
      we_q     <= 1'b0;
      ok_q     <= 1'b0;
      m_gnt    <= 1'b0;
      c_gnt    <= 1'b0;
      m_rvalid <= 1'b0;
      c_rvalid <= 1'b0;
      m_err    <= 1'b0;
      c_err    <= 1'b0;
      dm_rd    <= 1'b0;
      dm_wr    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
    end else begin
      m_gnt    <= 1'b0;
      c_gnt    <= 1'b0;
      m_rvalid <= 1'b0;
      c_rvalid <= 1'b0;
      m_err    <= 1'b0;
      c_err    <= 1'b0;
      case (state)
        // Stage 0 -> 1: arbitrate and latch the winning request.
        IDLE: begin
          if (!c_req || pick_c)
            wait_cnt <= '0;
          else if (wait_cnt != WAIT_LIM)
            wait_cnt <= wait_cnt + CW'(1);
          if (m_req || c_req) begin
            state    <= ACCESS;
            win_c    <= pick_c;
            we_q     <= sel_we;
            ok_q     <= sel_ok;
            m_gnt    <= ~pick_c;
            c_gnt    <= pick_c;
            dm_rd    <= ~sel_we & sel_ok;
            dm_wr    <= sel_we & sel_ok;
            dm_addr  <= sel_addr;
            dm_wdata <= sel_wdata;
          end
        end
        // Stage 1 -> 2: close the memory cycle and report the outcome.
        ACCESS: begin
          state    <= IDLE;
          dm_rd    <= 1'b0;
          dm_wr    <= 1'b0;
          dm_addr  <= '0;
          dm_wdata <= '0;
          if (ok_q && !we_q) begin
            m_rvalid <= ~win_c;
            c_rvalid <= win_c;
          end
          if (!ok_q) begin
            m_err <= ~win_c;
            c_err <= win_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is only observed through the rvalid gating below, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == ACCESS && ok_q && !we_q)
      rdata_p1 <= dm_rdata;
  end

  assign m_rdata = m_rvalid ? rdata_p1 : '0;
  assign c_rdata = c_rvalid ? rdata_p1 : '0;

endmodule

// File: tb/tb_dm_access_arbiter.sv
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req, m_we, c_req, c_we;
  logic [31:0] m_addr, m_wdata, c_addr, c_wdata;

  logic        m_gnt, m_rvalid, m_err, c_gnt, c_rvalid, c_err, dm_rd, dm_wr;
  logic [31:0] m_rdata, c_rdata, dm_addr, dm_wdata, dm_rdata;

  logic        m_gnt1, m_rvalid1, m_err1, c_gnt1, c_rvalid1, c_err1, dm_rd1, dm_wr1;
  logic [31:0] m_rdata1, c_rdata1, dm_addr1, dm_wdata1, dm_rdata1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_access_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  // Companion fixed-priority variant; reads only, its writes never reach memory.
  dm_access_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(0)) dut_fix (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt1), .m_rvalid(m_rvalid1), .m_rdata(m_rdata1), .m_err(m_err1),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1), .c_err(c_err1),
    .dm_rd(dm_rd1), .dm_wr(dm_wr1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1)
  );

  // Data memory model: 16 words, negedge write, combinational read.
  function automatic logic [31:0] init_val(input int i);
    if (i == 1) return 32'd32;
    if (i == 2) return 32'd4;
    return 32'h100 + 32'(i * 4);
  endfunction

  logic [31:0] mem [16];
  bit loaded;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (dm_wr) begin
      mem[dm_addr[5:2]] <= dm_wdata;
    end
  end

  assign dm_rdata  = mem[dm_addr[5:2]];
  assign dm_rdata1 = mem[dm_addr1[5:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_c;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic do_access(input vec_t v, input int idx);
    logic rd_exp, wr_exp;
    string tag;
    rd_exp = !v.we && !v.exp_err;
    wr_exp = v.we && !v.exp_err;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    if (v.is_c) begin
      c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
    end else begin
      m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata;
    end
    @(negedge clk);
    chk({tag, " no early gnt"}, {m_gnt, c_gnt}, 2'b00);
    @(posedge clk); @(negedge clk);
    chk({tag, " own gnt"}, v.is_c ? c_gnt : m_gnt, 1'b1);
    chk({tag, " other gnt"}, v.is_c ? m_gnt : c_gnt, 1'b0);
    chk({tag, " dm_rd"}, dm_rd, rd_exp);
    chk({tag, " dm_wr"}, dm_wr, wr_exp);
    chk({tag, " dm_addr"}, dm_addr, v.addr);
    if (v.we) chk({tag, " dm_wdata"}, dm_wdata, v.wdata);
    m_req = 1'b0; c_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, " rvalid"}, v.is_c ? c_rvalid : m_rvalid, rd_exp);
    chk({tag, " err"}, v.is_c ? c_err : m_err, v.exp_err);
    chk({tag, " rdata"}, v.is_c ? c_rdata : m_rdata, v.exp_rdata);
    chk({tag, " other quiet"}, v.is_c ? {m_rvalid, m_err, m_rdata} : {c_rvalid, c_err, c_rdata}, 34'd0);
    chk({tag, " gnt cleared"}, {m_gnt, c_gnt, dm_rd, dm_wr}, 4'd0);
    chk({tag, " dm_addr idle"}, dm_addr, 32'd0);
  endtask

  bit exp_c [8];

  initial begin
    vecs[0] = '{is_c: 0, we: 0, addr: 32'h08, wdata: 32'h0,        exp_err: 0, exp_rdata: 32'd4};
    vecs[1] = '{is_c: 1, we: 1, addr: 32'h10, wdata: 32'hDEADBEEF, exp_err: 0, exp_rdata: 32'd0};
    vecs[2] = '{is_c: 0, we: 0, addr: 32'h10, wdata: 32'h0,        exp_err: 0, exp_rdata: 32'hDEADBEEF};
    vecs[3] = '{is_c: 0, we: 1, addr: 32'h06, wdata: 32'h11111111, exp_err: 1, exp_rdata: 32'd0};
    vecs[4] = '{is_c: 0, we: 1, addr: 32'h40, wdata: 32'h22222222, exp_err: 1, exp_rdata: 32'd0};
    vecs[5] = '{is_c: 0, we: 0, addr: 32'h04, wdata: 32'h0,        exp_err: 0, exp_rdata: 32'd32};
    vecs[6] = '{is_c: 1, we: 0, addr: 32'h10, wdata: 32'h0,        exp_err: 0, exp_rdata: 32'hDEADBEEF};
    vecs[7] = '{is_c: 1, we: 0, addr: 32'h3C, wdata: 32'h0,        exp_err: 0, exp_rdata: 32'h13C};
    vecs[8] = '{is_c: 1, we: 0, addr: 32'h41, wdata: 32'h0,        exp_err: 1, exp_rdata: 32'd0};
    exp_c = '{0, 0, 0, 1, 0, 0, 0, 1};

    reset = 1'b1;
    m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;

    // Reset state
    #12;
    chk("reset gnt/rvalid/err", {m_gnt, c_gnt, m_rvalid, c_rvalid, m_err, c_err}, 6'd0);
    chk("reset dm ctrl", {dm_rd, dm_wr}, 2'd0);
    chk("reset dm addr/wdata", {dm_addr, dm_wdata}, 64'd0);
    chk("reset rdata", {m_rdata, c_rdata}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset idle", {m_gnt, c_gnt, dm_rd, dm_wr}, 4'd0);

    // Single accesses from the table
    for (int i = 0; i < 9; i++) do_access(vecs[i], i);
    chk("invalid writes left word1", mem[1], 32'd32);
    chk("invalid write at 0x06 left word2", mem[2], 32'd4);

    // Both requesters held: M,M,M,C rotation; fixed-priority variant always C
    @(posedge clk); #1;
    m_req = 1; m_we = 0; m_addr = 32'h08;
    c_req = 1; c_we = 0; c_addr = 32'h04;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk($sformatf("rot m_gnt %0d", k / 2), m_gnt, !exp_c[k / 2]);
        chk($sformatf("rot c_gnt %0d", k / 2), c_gnt, exp_c[k / 2]);
        chk($sformatf("fix gnt %0d", k / 2), {m_gnt1, c_gnt1}, 2'b01);
      end else begin
        chk($sformatf("rot gap %0d", k), {m_gnt, c_gnt}, 2'b00);
        if (exp_c[k / 2]) chk($sformatf("rot c_rdata %0d", k), c_rdata, 32'd32);
        else              chk($sformatf("rot m_rdata %0d", k), m_rdata, 32'd4);
        chk($sformatf("fix c_rdata %0d", k), c_rdata1, 32'd32);
      end
    end
    c_req = 0;
    @(negedge clk);
    chk("fix m wins after c drops", {m_gnt1, c_gnt1}, 2'b10);
    chk("rot m wins after c drops", {m_gnt, c_gnt}, 2'b10);
    m_req = 0;
    @(negedge clk);
    chk("fix m_rdata", {m_rvalid1, m_rdata1}, {1'b1, 32'd4});

    // Reset in the middle of a companion write
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_addr = 32'h0C; c_wdata = 32'h55AA55AA;
    @(posedge clk); #2;
    chk("abort pre dm_wr", {dm_wr, c_gnt}, 2'b11);
    #1 reset = 1'b1; c_req = 0;
    #1;
    chk("abort dm_wr drops", {dm_wr, c_gnt, dm_addr}, 34'd0);
    @(negedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort quiet %0d", k), {c_gnt, c_err, c_rvalid, dm_wr, m_gnt}, 5'd0);
    end
    chk("abort no write", mem[3], 32'h10C);
    do_access('{is_c: 0, we: 0, addr: 32'h0C, wdata: 32'h0, exp_err: 0, exp_rdata: 32'h10C}, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
